// File: rtl/matrix_transpose_buffer.sv
// matrix_transpose_buffer
//   ROWS x COLS frame buffer. A full matrix is captured row-major from a
//   valid/ready input stream. It is then replayed on a valid/ready output
//   stream, either row-major (mode_tr=0) or column-major (mode_tr=1).
//   mode_tr is sampled when the last element of the frame is accepted.
//
//   Build option: DOUBLE_BUFFER_EN
//     defined   : two banks with full flags, so one frame can be written
//                 while the other is read. Sustains one element per cycle
//                 in both directions.
//     undefined : single bank with strict FILL/DRAIN alternation.
//
//   state | meaning (single-bank build)
//   FILL  | accepting input elements, output idle
//   DRAIN | replaying the stored frame, input stalled
module matrix_transpose_buffer #(
  parameter int DATA_W = 4,
  parameter int ROWS   = 4,
  parameter int COLS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              mode_tr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [RW-1:0] rd_row_q, rd_row_d;
  logic [CW-1:0] rd_col_q, rd_col_d;

  logic wr_fire;
  logic rd_fire;
  logic wr_at_end;
  logic rd_at_end;
  logic rd_done;
  logic rd_mode;

  // Index positions of the final element, independent of handshakes so the
  // control logic can use them without forming a loop through the ready/valid
  // outputs.
  assign wr_at_end = (wr_row_q == ROW_MAX) && (wr_col_q == COL_MAX);
  assign rd_at_end = (rd_row_q == ROW_MAX) && (rd_col_q == COL_MAX);

  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = out_valid && out_ready;
  assign rd_done  = rd_fire && rd_at_end;
  assign out_last = out_valid && rd_at_end;

  // Write index: column fastest, explicit wrap so non-power-of-2 sizes work.
  always_comb begin
    wr_row_d = wr_row_q;
    wr_col_d = wr_col_q;
    if (wr_fire) begin
      if (wr_col_q == COL_MAX) begin
        wr_col_d = '0;
        if (wr_row_q == ROW_MAX) begin
          wr_row_d = '0;
        end else begin
          wr_row_d = wr_row_q + 1'b1;
        end
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end
  end

  // Read index: order depends on the mode latched for the frame being read.
  always_comb begin
    rd_row_d = rd_row_q;
    rd_col_d = rd_col_q;
    if (rd_fire) begin
      if (rd_at_end) begin
        rd_row_d = '0;
        rd_col_d = '0;
      end else if (!rd_mode) begin
        if (rd_col_q == COL_MAX) begin
          rd_col_d = '0;
          rd_row_d = rd_row_q + 1'b1;
        end else begin
          rd_col_d = rd_col_q + 1'b1;
        end
      end else begin
        if (rd_row_q == ROW_MAX) begin
          rd_row_d = '0;
          rd_col_d = rd_col_q + 1'b1;
        end else begin
          rd_row_d = rd_row_q + 1'b1;
        end
      end
    end
  end

  // Index counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_row_q <= '0;
      wr_col_q <= '0;
      rd_row_q <= '0;
      rd_col_q <= '0;
    end else begin
      wr_row_q <= wr_row_d;
      wr_col_q <= wr_col_d;
      rd_row_q <= rd_row_d;
      rd_col_q <= rd_col_d;
    end
  end

`ifdef DOUBLE_BUFFER_EN

  logic [DATA_W-1:0] mem_q [2][ROWS][COLS];
  logic [1:0] full_q, full_d;
  logic [1:0] mode_q, mode_d;
  logic       wr_b_q, wr_b_d;
  logic       rd_b_q, rd_b_d;

  assign in_ready = !full_q[wr_b_q];
  assign out_valid = full_q[rd_b_q];
  assign out_data = mem_q[rd_b_q][rd_row_q][rd_col_q];
  assign rd_mode = mode_q[rd_b_q];

  // Frame storage; the writer only touches a bank that is not full and the
  // reader only a bank that is full, so they never share a bank.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_b_q][wr_row_q][wr_col_q] <= in_data;
    end
  end

  // Bank handoff: a completed write marks its bank full, a completed read
  // frees its bank. Set and clear always target different banks.
  always_comb begin
    full_d = full_q;
    mode_d = mode_q;
    wr_b_d = wr_b_q;
    rd_b_d = rd_b_q;
    if (in_valid && !full_q[wr_b_q] && wr_at_end) begin
      full_d[wr_b_q] = 1'b1;
      mode_d[wr_b_q] = mode_tr;
      wr_b_d = ~wr_b_q;
    end
    if (out_ready && full_q[rd_b_q] && rd_at_end) begin
      full_d[rd_b_q] = 1'b0;
      rd_b_d = ~rd_b_q;
    end
  end

  // Bank control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 2'b00;
      mode_q <= 2'b00;
      wr_b_q <= 1'b0;
      rd_b_q <= 1'b0;
    end else begin
      full_q <= full_d;
      mode_q <= mode_d;
      wr_b_q <= wr_b_d;
      rd_b_q <= rd_b_d;
    end
  end

`else

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem_q [ROWS][COLS];
  state_t state_q, state_d;
  logic   mode_q, mode_d;

  assign out_data = mem_q[rd_row_q][rd_col_q];
  assign rd_mode = mode_q;

  // Frame storage; written only while filling, so it is stable during drain.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_row_q][wr_col_q] <= in_data;
    end
  end

  // State register and readout mode latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    in_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && wr_at_end) begin
          state_d = S_DRAIN;
          mode_d = mode_tr;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && rd_at_end) begin
          state_d = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

`endif

endmodule

// File: tb/tb_matrix_transpose_buffer.sv
// Directed bench for matrix_transpose_buffer (4x4 and 2x3 instances).
module tb_matrix_transpose_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, mode_tr, out_valid, out_ready, out_last;
  logic [3:0] in_data, out_data;

  logic       b_in_valid, b_in_ready, b_mode_tr, b_out_valid, b_out_ready, b_out_last;
  logic [3:0] b_in_data, b_out_data;

  int errors = 0;
  int checks = 0;

  logic [3:0] frame_data [0:31];
  logic [3:0] got [0:31];
  logic       got_last [0:31];
  int         ngot;
  int         first_it, last_it;

  always #5 clk = ~clk;

  matrix_transpose_buffer #(.DATA_W(4), .ROWS(4), .COLS(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode_tr(mode_tr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  matrix_transpose_buffer #(.DATA_W(4), .ROWS(2), .COLS(3)) u_dut23 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .mode_tr(b_mode_tr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
  );

  // Push frame_data[first .. first+n-1]; called and returns at a negedge.
  task automatic push_frame(input int first, input int n, input bit gaps, output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = frame_data[first + i];
      for (int g = 0; g < 50 && !in_ready; g++) @(negedge clk);
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Gather n output transfers; called and returns at a negedge.
  task automatic collect(input int n, input bit stall);
    bit tog;
    int it;
    tog = 1'b1;
    it = 0;
    ngot = 0;
    first_it = -1;
    last_it = -1;
    while (ngot < n && it < 400) begin
      out_ready = stall ? tog : 1'b1;
      tog = ~tog;
      if (out_valid && out_ready) begin
        got[ngot] = out_data;
        got_last[ngot] = out_last;
        if (ngot == 0) first_it = it;
        last_it = it;
        ngot++;
      end
      @(negedge clk);
      it++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; mode_tr = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_mode_tr = 1'b0; b_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b out_last=%b, want 1 0 0", in_ready, out_valid, out_last);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_row_major();
    int acc;
    mode_tr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) frame_data[i] = 4'(i);
    push_frame(0, 15, 1'b0, acc);
    checks++;
    if (acc !== 15 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_15_accepts: accepted=%0d out_valid=%b, want 15 0", acc, out_valid);
    end
    push_frame(15, 1, 1'b0, acc);
    checks++;
    if (acc !== 1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rm_latency: accepted=%0d out_valid=%b, want 1 1", acc, out_valid);
    end
`ifndef DOUBLE_BUFFER_EN
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_in_ready_drain: in_ready=%b, want 0", in_ready);
    end
`endif
    collect(16, 1'b0);
    checks++;
    if (ngot !== 16 || (last_it - first_it) !== 15) begin
      errors++;
      $display("FAIL rm_count: got %0d over %0d cycles, want 16 over 16", ngot, last_it - first_it + 1);
    end
    for (int k = 0; k < ngot; k++) begin
      checks++;
      if (got[k] !== 4'(k) || got_last[k] !== (k == 15)) begin
        errors++;
        $display("FAIL rm_data[%0d]: data=%0d last=%b, want %0d %b", k, got[k], got_last[k], k, k == 15);
      end
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_return_fill: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_transpose();
    int acc;
    int n;
    int it;
    logic [3:0] exp23 [0:5];
    logic [3:0] bgot [0:5];
    logic       blast [0:5];
    mode_tr = 1'b1;
    for (int i = 0; i < 16; i++) frame_data[i] = 4'(i);
    push_frame(0, 16, 1'b0, acc);
    mode_tr = 1'b0;
    collect(16, 1'b0);
    checks++;
    if (acc !== 16 || ngot !== 16) begin
      errors++;
      $display("FAIL tr_count: accepted=%0d drained=%0d, want 16 16", acc, ngot);
    end
    for (int k = 0; k < ngot; k++) begin
      checks++;
      if (got[k] !== 4'((k % 4) * 4 + k / 4) || got_last[k] !== (k == 15)) begin
        errors++;
        $display("FAIL tr_data[%0d]: data=%0d last=%b, want %0d %b", k, got[k], got_last[k], (k % 4) * 4 + k / 4, k == 15);
      end
    end
    // 2x3 transpose
    exp23[0] = 4'd0; exp23[1] = 4'd3; exp23[2] = 4'd1;
    exp23[3] = 4'd4; exp23[4] = 4'd2; exp23[5] = 4'd5;
    b_mode_tr = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_in_valid = 1'b1;
      b_in_data = 4'(i);
      for (int g = 0; g < 50 && !b_in_ready; g++) @(negedge clk);
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    n = 0;
    it = 0;
    while (n < 6 && it < 100) begin
      if (b_out_valid) begin
        bgot[n] = b_out_data;
        blast[n] = b_out_last;
        n++;
      end
      @(negedge clk);
      it++;
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL tr23_count: drained=%0d, want 6", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (bgot[k] !== exp23[k] || blast[k] !== (k == 5)) begin
        errors++;
        $display("FAIL tr23_data[%0d]: data=%0d last=%b, want %0d %b", k, bgot[k], blast[k], exp23[k], k == 5);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int n;
    int it;
    bit tog;
    bit stalled;
    logic [3:0] prev_d;
    logic       prev_l;
    mode_tr = 1'b0;
    for (int i = 0; i < 16; i++) frame_data[i] = 4'(15 - i);
    push_frame(0, 16, 1'b0, acc);
    n = 0; it = 0; tog = 1'b1; stalled = 1'b0;
    prev_d = '0; prev_l = 1'b0;
    while (n < 16 && it < 200) begin
      if (stalled) begin
        checks++;
        if (out_data !== prev_d || out_last !== prev_l) begin
          errors++;
          $display("FAIL bp_stable: data=%0d last=%b, want %0d %b", out_data, out_last, prev_d, prev_l);
        end
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready: in_ready=%b, want 0", in_ready);
      end
      out_ready = tog;
      tog = ~tog;
      if (out_valid && out_ready) begin
        got[n] = out_data;
        got_last[n] = out_last;
        n++;
      end
      stalled = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
      @(negedge clk);
      it++;
    end
    out_ready = 1'b1;
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL bp_count: drained=%0d, want 16", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got[k] !== 4'(15 - k) || got_last[k] !== (k == 15)) begin
        errors++;
        $display("FAIL bp_data[%0d]: data=%0d last=%b, want %0d %b", k, got[k], got_last[k], 15 - k, k == 15);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    int acc;
    for (int i = 0; i < 16; i++) frame_data[i] = 4'(i);
    push_frame(0, 7, 1'b0, acc);
    checks++;
    if (acc !== 7) begin
      errors++;
      $display("FAIL rst_partial: accepted=%0d, want 7", acc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: in_ready=%b out_valid=%b out_last=%b, want 1 0 0", in_ready, out_valid, out_last);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mode_tr = 1'b0;
    for (int i = 0; i < 16; i++) frame_data[i] = 4'((i * 5) % 16);
    push_frame(0, 16, 1'b0, acc);
    collect(16, 1'b0);
    checks++;
    if (acc !== 16 || ngot !== 16) begin
      errors++;
      $display("FAIL rst_fresh_count: accepted=%0d drained=%0d, want 16 16", acc, ngot);
    end
    for (int k = 0; k < ngot; k++) begin
      checks++;
      if (got[k] !== 4'((k * 5) % 16) || got_last[k] !== (k == 15)) begin
        errors++;
        $display("FAIL rst_fresh[%0d]: data=%0d last=%b, want %0d %b", k, got[k], got_last[k], (k * 5) % 16, k == 15);
      end
    end
  endtask

  task automatic test_gaps_mode_flip();
    int acc;
    mode_tr = 1'b1;
    for (int i = 0; i < 16; i++) frame_data[i] = 4'((i + 3) % 16);
    push_frame(0, 16, 1'b1, acc);
    // flip mode and offer junk while draining
    mode_tr = 1'b0;
    in_valid = 1'b1;
    in_data = 4'd9;
    collect(16, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (acc !== 16 || ngot !== 16) begin
      errors++;
      $display("FAIL gap_count: accepted=%0d drained=%0d, want 16 16", acc, ngot);
    end
    for (int k = 0; k < ngot; k++) begin
      checks++;
      if (got[k] !== 4'(((k % 4) * 4 + k / 4 + 3) % 16)) begin
        errors++;
        $display("FAIL gap_tr[%0d]: data=%0d, want %0d", k, got[k], ((k % 4) * 4 + k / 4 + 3) % 16);
      end
    end
    // next frame must start at index 0: junk was not captured
    mode_tr = 1'b0;
    for (int i = 0; i < 16; i++) frame_data[i] = 4'(15 - i);
    push_frame(0, 16, 1'b0, acc);
    collect(16, 1'b0);
    checks++;
    if (ngot !== 16) begin
      errors++;
      $display("FAIL gap_next_count: drained=%0d, want 16", ngot);
    end
    for (int k = 0; k < ngot; k++) begin
      checks++;
      if (got[k] !== 4'(15 - k) || got_last[k] !== (k == 15)) begin
        errors++;
        $display("FAIL gap_next[%0d]: data=%0d last=%b, want %0d %b", k, got[k], got_last[k], 15 - k, k == 15);
      end
    end
  endtask

`ifdef DOUBLE_BUFFER_EN
  task automatic test_double_buffer();
    for (int i = 0; i < 32; i++) frame_data[i] = (i < 16) ? 4'(i) : 4'((i * 7) % 16);
    mode_tr = 1'b0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          in_valid = 1'b1;
          in_data = frame_data[i];
          if (i == 16) mode_tr = 1'b1;
          checks++;
          if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL db_in_ready[%0d]: in_ready=%b, want 1", i, in_ready);
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      collect(32, 1'b0);
    join
    checks++;
    if (ngot !== 32 || (last_it - first_it) !== 31) begin
      errors++;
      $display("FAIL db_contiguous: got %0d over %0d cycles, want 32 over 32", ngot, last_it - first_it + 1);
    end
    for (int k = 0; k < ngot; k++) begin
      logic [3:0] e;
      e = (k < 16) ? 4'(k) : 4'((((k - 16) % 4) * 4 + (k - 16) / 4) * 7 % 16);
      checks++;
      if (got[k] !== e || got_last[k] !== (k == 15 || k == 31)) begin
        errors++;
        $display("FAIL db_data[%0d]: data=%0d last=%b, want %0d %b", k, got[k], got_last[k], e, k == 15 || k == 31);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_row_major();
    test_transpose();
`ifdef DOUBLE_BUFFER_EN
    test_mid_frame_reset();
    test_double_buffer();
`else
    test_backpressure();
    test_mid_frame_reset();
    test_gaps_mode_flip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
